// File: rtl/fp_norm_pkg.sv
// Shared types and widths for the FP normalization stage.
// Holds the FSM state enum and the mantissa/exponent field sizes.
package fp_norm_pkg;

  localparam int MANT_W = 25;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fp_pack.sv
// Packs sign, exponent and fraction into an IEEE-754 single word.
// Ports: i_sign, i_exp[7:0], i_frac[22:0] -> o_word[31:0].
module fp_pack
  import fp_norm_pkg::*;
(
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [FRAC_W-1:0] i_frac,
  output logic [31:0]       o_word
);

  assign o_word = {i_sign, i_exp, i_frac};

endmodule

// File: rtl/fp_norm_stage.sv
// Iterative normalizer: one shift per cycle, truncating, with a held result.
// Ports: in_* operand handshake, out_* result handshake, clk/reset_n.
module fp_norm_stage
  import fp_norm_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result
);

  state_e              r_state;
  state_e              w_state_nx;
  logic                r_sign;
  logic [EXP_W:0]      r_exp;
  logic [MANT_W-1:0]   r_mant;
  logic                r_special;
  logic [31:0]         r_result;

  logic [EXP_W:0]      w_exp_nx;
  logic [EXP_W:0]      w_exp_inc;
  logic [MANT_W-1:0]   w_mant_nx;
  logic                w_done;
  logic [EXP_W-1:0]    w_pk_exp;
  logic [FRAC_W-1:0]   w_pk_frac;
  logic [31:0]         w_packed;

  assign w_exp_inc = r_exp + 9'd1;

  always_comb begin
    w_state_nx = r_state;
    w_exp_nx   = r_exp;
    w_mant_nx  = r_mant;
    w_done     = 1'b0;
    w_pk_exp   = r_exp[EXP_W-1:0];
    w_pk_frac  = r_mant[FRAC_W-1:0];
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) w_state_nx = ST_NORM;
      end
      ST_NORM: begin
        if (r_mant == '0) begin
          w_done    = 1'b1;
          w_pk_exp  = '0;
          w_pk_frac = '0;
        end else if (r_special) begin
          w_done    = 1'b1;
          w_pk_exp  = EXP_MAX;
        end else if (r_mant[24]) begin
          w_mant_nx = r_mant >> 1;
          w_exp_nx  = w_exp_inc;
          // carry pushed the exponent to all-ones: saturate to infinity
          if (w_exp_inc == 9'd255) begin
            w_done    = 1'b1;
            w_pk_exp  = EXP_MAX;
            w_pk_frac = '0;
          end
        end else if (!r_mant[23] && r_exp <= 9'd1) begin
          w_done    = 1'b1;
          w_pk_exp  = '0;
          w_pk_frac = '0;
        end else if (!r_mant[23]) begin
          w_mant_nx = r_mant << 1;
          w_exp_nx  = r_exp - 9'd1;
        end else begin
          w_done = 1'b1;
        end
        if (w_done) w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  fp_pack u_pack (
    .i_sign (r_sign),
    .i_exp  (w_pk_exp),
    .i_frac (w_pk_frac),
    .o_word (w_packed)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_mant    <= '0;
      r_special <= 1'b0;
      r_result  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign    <= in_sign;
            r_exp     <= {1'b0, in_exp};
            r_mant    <= in_mant;
            r_special <= (in_exp == EXP_MAX);
          end
        end
        ST_NORM: begin
          r_exp  <= w_exp_nx;
          r_mant <= w_mant_nx;
          if (w_done) r_result <= w_packed;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_result;

endmodule

// File: tb/tb_fp_norm_stage.sv
// Directed bench for fp_norm_stage: vector table plus
// back-pressure, back-to-back and mid-operation reset sequences.
module tb_fp_norm_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int n_cmp;
  int n_err;

  fp_norm_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e,
                       input logic [24:0] m);
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: out_valid=0 after %0d cycles, expected 1",
               name, lat);
    end
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, " idle_valid"}, {31'b0, out_valid}, 32'd0);
    check({name, " idle_ready"}, {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    drive(v.sign, v.exp, v.mant);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({v.name, " accepted"}, {31'b0, in_ready}, 32'd0);
    wait_done(v.name, lat);
    check({v.name, " latency"}, lat, v.lat);
    check({v.name, " result"}, out_result, v.res);
    consume(v.name);
  endtask

  initial begin
    int   lat;
    vec_t v;
    logic [31:0] held;

    n_cmp     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;

    vecs.push_back('{"normal",    1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1});
    vecs.push_back('{"carry",     1'b1, 8'h7F, 25'h1000000, 32'hC0000000, 2});
    vecs.push_back('{"ovf",       1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1});
    vecs.push_back('{"maxshift",  1'b0, 8'h7F, 25'h0000001, 32'h34000000, 24});
    vecs.push_back('{"underflow", 1'b0, 8'h05, 25'h0000100, 32'h00000000, 5});
    vecs.push_back('{"negzero",   1'b1, 8'h40, 25'h0000000, 32'h80000000, 1});
    vecs.push_back('{"nanpass",   1'b0, 8'hFF, 25'h0400001, 32'h7FC00001, 1});
    vecs.push_back('{"ffzero",    1'b0, 8'hFF, 25'h0000000, 32'h00000000, 1});
    vecs.push_back('{"oneshift",  1'b0, 8'h80, 25'h0400000, 32'h3F800000, 2});
    vecs.push_back('{"carrytrnc", 1'b0, 8'h7F, 25'h1000001, 32'h40000000, 2});
    vecs.push_back('{"minexp",    1'b0, 8'h01, 25'h0800000, 32'h00800000, 1});
    vecs.push_back('{"exp1shift", 1'b1, 8'h01, 25'h0400000, 32'h80000000, 1});

    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst out_result", out_result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

    // back-pressure, then an operand waiting across the consume edge
    drive(1'b0, 8'h7F, 25'h0800000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done("bp", lat);
    held = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp stable", out_result, held);
      check("bp valid", {31'b0, out_valid}, 32'd1);
      check("bp in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sign   = 1'b1;
    in_exp    = 8'h7F;
    in_mant   = 25'h1000000;
    @(posedge clk);
    #1;
    check("b2b consumed", {31'b0, out_valid}, 32'd0);
    check("b2b idle", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b accepted", {31'b0, in_ready}, 32'd0);
    wait_done("b2b", lat);
    check("b2b latency", lat, 2);
    check("b2b result", out_result, 32'hC0000000);
    consume("b2b");

    // reset in the middle of a long normalization
    drive(1'b0, 8'h7F, 25'h0000001);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mrst out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst in_ready", {31'b0, in_ready}, 32'd1);
    check("mrst out_result", out_result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    v = '{"after_rst", 1'b1, 8'h81, 25'h0200000, 32'hBF800000, 3};
    run_op(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_norm_stage.md
FP_NORM_STAGE -- requirements
Module: fp_norm_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream offers an operand.
REQ-005 in_ready  output  1  block accepts an operand; high only in IDLE.
REQ-006 in_sign  input  1  result sign.
REQ-007 in_exp  input  8  biased exponent of the unnormalized value.
REQ-008 in_mant  input  25  mantissa from the preceding 25-bit select stage:
- bit 24 = carry
- bit 23 = hidden bit
- bits 22:0 = fraction
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  downstream consumes result.
REQ-011 out_result  output  32  IEEE-754 single: {sign, exp[7:0], frac[22:0]}.

Function
REQ-012 The block SHALL implement states IDLE, NORM and DONE.
REQ-013 IDLE -> NORM SHALL occur on an edge with in_valid && in_ready; sign, exp (zero-extended to 9 bits internally) and mant are registered.
REQ-014 In NORM, each cycle SHALL perform exactly one action, in this priority order:
- mant == 0: result = {sign, 31'b0}; go to DONE.
- exp == 8'hFF at accept: pass through {sign, 8'hFF, mant[22:0]}; go to DONE.
- mant[24] == 1: shift right 1 with truncation; exp + 1. If the new exp == 255, result = {sign, 8'hFF, 23'b0} (overflow to infinity) and go to DONE; otherwise stay in NORM.
- mant[23] == 0 and exp <= 1: result = {sign, 31'b0} (flush underflow); go to DONE.
- mant[23] == 0: shift left 1; exp - 1; stay in NORM.
- otherwise (normalized): result = {sign, exp[7:0], mant[22:0]}; go to DONE.
REQ-015 Latency, measured from the accept edge E0:
- already normalized: out_valid high after E1.
- carry set: out_valid high after E2.
- k left shifts needed: out_valid high after E(k+1).
- maximum: E24.
REQ-016 In DONE, out_valid SHALL be 1 and out_result SHALL stay stable until an edge with out_ready = 1, which returns the block to IDLE.
REQ-017 in_ready SHALL be 0 in NORM and DONE. No new operand is accepted in the cycle the result is consumed; the next accept is possible one cycle later.
REQ-018 Rounding SHALL be truncation (round toward zero).
REQ-019 Exponent arithmetic SHALL use 9 bits internally so that wrap-around cannot occur.

Reset
REQ-020 reset_n low SHALL asynchronously force:
- state = IDLE
- out_valid = 0
- out_result = 32'h0
- internal mant/exp/sign = 0
REQ-021 A reset during NORM or DONE SHALL abandon the operation with no output. in_ready SHALL read 1 from the reset assertion onward.

Structure
REQ-022 Package fp_norm_pkg SHALL hold:
- the state enum
- MANT_W = 25, EXP_W = 8, EXP_MAX = 8'hFF, FRAC_W = 23
REQ-023 The field packing SHALL be a combinational sub-module fp_pack (sign, exp, frac -> 32-bit word); everything else SHALL be in fp_norm_stage.

Verification
REQ-024 Normalized input: sign=0, exp=8'h7F, mant=25'h0800000 -> out_result 32'h3F800000, out_valid after E1.
REQ-025 Carry input: sign=1, exp=8'h7F, mant=25'h1000000 -> 32'hC0000000 after E2. Overflow variant: exp=8'hFE -> 32'h7F800000.
REQ-026 Maximum left shift: sign=0, exp=8'h7F, mant=25'h0000001 -> 23 shifts, 32'h34000000, out_valid after E24.
REQ-027 Underflow: exp=8'h05, mant=25'h0000100 -> 32'h00000000. Zero mantissa with sign=1 -> 32'h80000000.
REQ-028 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_result stable, in_ready=0. Then assert out_ready -> IDLE, and back-to-back operands are accepted one cycle apart from consumption.
REQ-029 Reset mid-NORM (mant=25'h0000001, reset_n pulsed low at E5) -> out_valid 0, in_ready 1 immediately. The next operand completes correctly.
